// File: rtl/imem_loader.sv
// Byte-stream instruction memory loader: takes a little-endian word count followed by
// little-endian instruction words and writes them sequentially from address 0.
module imem_loader #(
  parameter int DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  typedef enum logic [1:0] {IDLE, LEN, DATA, FINISH} state_t;

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  state_t      state, state_d;
  logic [1:0]  byte_idx;
  logic [23:0] sh;        // previous bytes of the current word, newest at the top
  logic [31:0] len;
  logic [31:0] word_idx;
  logic        take;
  logic        last_byte;
  logic [31:0] full;

  assign in_ready  = (state == LEN) || (state == DATA);
  assign cpu_hold  = (state != IDLE);
  assign done      = (state == FINISH);
  // abort beats a byte arriving in the same cycle
  assign take      = in_valid && in_ready && !abort;
  assign last_byte = take && (byte_idx == 2'd3);
  assign full      = {in_data, sh};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:   if (start) state_d = LEN;
      LEN: begin
        if (abort) state_d = IDLE;
        else if (last_byte) begin
          if (full == 32'd0)         state_d = FINISH;
          else if (full > DEPTH_W)   state_d = IDLE;
          else                       state_d = DATA;
        end
      end
      DATA: begin
        if (abort) state_d = IDLE;
        else if (last_byte && (word_idx == len - 32'd1)) state_d = FINISH;
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx <= '0;
      sh       <= '0;
      len      <= '0;
      word_idx <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      error    <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            error    <= 1'b0;
            byte_idx <= '0;
            word_idx <= '0;
            len      <= '0;
            sh       <= '0;
          end
        end
        LEN, DATA: begin
          if (abort) begin
            error    <= 1'b1;
            byte_idx <= '0;
          end else if (take) begin
            byte_idx <= byte_idx + 2'd1;
            sh       <= {in_data, sh[23:8]};
            if (byte_idx == 2'd3) begin
              if (state == LEN) begin
                len <= full;
                if (full > DEPTH_W) error <= 1'b1;
              end else begin
                wr_en    <= 1'b1;
                wr_addr  <= {word_idx[29:0], 2'b00};
                wr_data  <= full;
                word_idx <= word_idx + 32'd1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: frames are modelled as byte lists and
// expected writes / done pulses are queued before driving; a monitor checks them.
module tb_imem_loader;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, wr_en, cpu_hold, done, error;
  logic [31:0] wr_addr, wr_data;

  imem_loader #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [31:0] a; logic [31:0] d;} wr_t;
  wr_t exp_wr[$];
  bit  exp_done[$];
  wr_t mon_e;
  bit  mon_d;
  int  n_chk = 0;
  int  n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // monitor: every write and done pulse must match the head of its queue
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (wr_en) begin
        if (exp_wr.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_write: got %h@%h expected none", wr_data, wr_addr);
        end else begin
          mon_e = exp_wr.pop_front();
          chk("wr_addr", wr_addr, mon_e.a);
          chk("wr_data", wr_data, mon_e.d);
        end
      end
      if (done) begin
        if (exp_done.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_done: got 1 expected 0");
        end else begin
          mon_d = exp_done.pop_front();
          chk("done_with_final_wr", 32'(wr_en), 32'(mon_d));
          chk("done_hold", 32'(cpu_hold), 1);
          chk("done_err", 32'(error), 0);
        end
      end
    end
  end

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ready"}, 32'(in_ready), 0);
    chk({nm, "_wr_en"}, 32'(wr_en), 0);
    chk({nm, "_wr_addr"}, wr_addr, 0);
    chk({nm, "_wr_data"}, wr_data, 0);
    chk({nm, "_hold"}, 32'(cpu_hold), 0);
    chk({nm, "_done"}, 32'(done), 0);
    chk({nm, "_err"}, 32'(error), 0);
  endtask

  // n: word count; ab: frame byte index carrying abort (-1 none); gapmode 0 none,
  // 1 one idle cycle before every byte, 2 random 0..2; st_ab: abort with start;
  // rst_at: frame byte index during which reset is pulsed (-1 none)
  task automatic run_frame(input int n, input int ab, input int gapmode,
                           input bit st_ab, input int rst_at);
    logic [7:0]  bytes[$];
    logic [31:0] nn;
    logic [31:0] w;
    int          gap, t, stop_at;
    bit          exp_err;
    nn = 32'(n);
    for (int i = 0; i < 4; i++) bytes.push_back(nn[8*i +: 8]);
    stop_at = (ab >= 0) ? ab : ((rst_at >= 0) ? rst_at : 1 << 30);
    if (n <= DEPTH) begin
      for (int k = 0; k < n; k++) begin
        w = $urandom;
        for (int i = 0; i < 4; i++) bytes.push_back(w[8*i +: 8]);
        if (4 + 4*k + 3 < stop_at) exp_wr.push_back({32'(4*k), w});
      end
      if (ab < 0 && rst_at < 0) exp_done.push_back(n > 0);
    end
    exp_err = (ab >= 0 || n > DEPTH) && rst_at < 0;

    @(negedge clk);
    start = 1'b1; abort = st_ab;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_ready", 32'(in_ready), 1);
    chk("start_err_clear", 32'(error), 0);

    for (int i = 0; i < bytes.size(); i++) begin
      if (ab >= 0 && i > ab) break;
      gap = (gapmode == 1) ? 1 : (gapmode == 2) ? $urandom_range(2, 0) : 0;
      repeat (gap) begin in_valid = 1'b0; @(negedge clk); end
      t = 0;
      while (!in_ready && t < 20) begin in_valid = 1'b0; @(negedge clk); t++; end
      if (!in_ready) begin chk("ready_timeout", 0, 1); break; end
      in_valid = 1'b1; in_data = bytes[i];
      if (i == rst_at) begin
        #2 rst_n = 1'b0;
        #1 chk_all_zero("midreset");
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        break;
      end
      abort = (i == ab);
      @(negedge clk);
      abort = 1'b0;
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("end_err", 32'(error), 32'(exp_err));
    chk("end_hold", 32'(cpu_hold), 0);
    chk("end_ready", 32'(in_ready), 0);
  endtask

  initial begin
    int n, ab;
    #1 chk_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // abort while idle does nothing
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("idle_abort_err", 32'(error), 0);
    chk("idle_abort_hold", 32'(cpu_hold), 0);

    run_frame(2, -1, 0, 0, -1);       // two words back to back
    run_frame(0, -1, 0, 0, -1);       // empty image
    run_frame(DEPTH + 1, -1, 0, 0, -1); // oversize length rejected
    run_frame(1, -1, 1, 0, -1);       // in_valid toggling
    run_frame(2, 10, 0, 0, -1);       // abort on 7th data byte
    run_frame(3, -1, 0, 1, -1);       // start and abort together
    run_frame(3, -1, 0, 0, 9);        // reset during DATA

    // bytes without a start are not taken after reset
    repeat (4) begin
      @(negedge clk); in_valid = 1'b1; in_data = 8'h5A;
      chk("nostart_ready", 32'(in_ready), 0);
    end
    @(negedge clk); in_valid = 1'b0;
    chk("nostart_hold", 32'(cpu_hold), 0);

    run_frame(1, 2, 0, 0, -1);        // abort during length
    run_frame(DEPTH, -1, 0, 0, -1);   // full-size image

    for (int r = 0; r < 20; r++) begin
      n  = $urandom_range(8, 0);
      ab = ($urandom_range(3, 0) == 0) ? $urandom_range(4 + 4*n - 1, 0) : -1;
      run_frame(n, ab, 2, 1'($urandom_range(1, 0)), -1);
    end

    repeat (4) @(negedge clk);
    chk("wr_queue_empty", 32'(exp_wr.size()), 0);
    chk("done_queue_empty", 32'(exp_done.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, default 1024, instruction memory size in 32-bit words (power of two, 4..65536).
REQ-002 Port clk  input  1  single clock, all state on rising edge.
REQ-003 Port rst_n  input  1  asynchronous active-low reset.
REQ-004 Port start  input  1  one-cycle request to begin a load frame.
REQ-005 Port abort  input  1  cancel an in-progress load.
REQ-006 Port in_valid  input  1  byte-stream data valid.
REQ-007 Port in_data  input  8  byte-stream data.
REQ-008 Port in_ready  output  1  loader accepts byte this cycle.
REQ-009 Port wr_en  output  1  instruction memory write strobe.
REQ-010 Port wr_addr  output  32  byte address of write (word aligned, [1:0]=0).
REQ-011 Port wr_data  output  32  instruction word to write.
REQ-012 Port cpu_hold  output  1  keeps core in reset/stall while loading.
REQ-013 Port done  output  1  one-cycle pulse on successful load completion.
REQ-014 Port error  output  1  sticky load failure flag.

Function
REQ-015 States IDLE, LEN, DATA, FINISH; byte accepted only when in_valid && in_ready.
REQ-016 in_ready SHALL be 1 in LEN and DATA, 0 in IDLE and FINISH.
REQ-017 IDLE: start=1 -> LEN, clear error, clear byte index, word index, and length; start in any other state ignored.
REQ-018 LEN: four accepted bytes form 32-bit word count N, little-endian (first byte = bits [7:0]).
REQ-019 After 4th LEN byte: N=0 -> FINISH; N>DEPTH -> IDLE with error=1, no writes; otherwise -> DATA.
REQ-020 DATA: bytes assembled little-endian per word; 2-bit byte index wraps 3->0.
REQ-021 On 4th byte of word k, wr_en SHALL be 1 for exactly the following cycle with wr_addr=4*k, wr_data=assembled word.
REQ-022 Word index increments per completed word; after word N-1 accepted -> FINISH.
REQ-023 FINISH lasts one cycle, asserting done=1 (registered, coincident with final wr_en if N>0), then -> IDLE.
REQ-024 cpu_hold SHALL be 1 in LEN, DATA, FINISH and 0 in IDLE.
REQ-025 Max throughput one byte per cycle; in_valid gaps stall assembly without losing partial word.
REQ-026 abort in LEN or DATA -> IDLE next cycle, error=1, partial word discarded, no wr_en for it; abort in IDLE/FINISH ignored.
REQ-027 abort and accepted 4th byte in same cycle: abort wins, no write issued.
REQ-028 start and abort same cycle in IDLE: start wins.
REQ-029 error stays 1 until next accepted start or reset.
REQ-030 Writes are strictly sequential from address 0; loader never reads memory.

Reset
REQ-031 rst_n=0 asynchronously forces IDLE, in_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=0, done=0, error=0, all counters 0.
REQ-032 Reset mid-load abandons frame silently (error=0); no write issued after reset assertion.
REQ-033 First load after reset requires a fresh start.

Verification
REQ-034 start; bytes 02 00 00 00, 13 00 00 00, B7 12 00 00 -> wr 0x00000013@0x0, then 0x000012B7@0x4, done one cycle, cpu_hold falls next cycle.
REQ-035 start; length 00 00 00 00 -> no wr_en, done pulses one cycle after 4th byte, error=0.
REQ-036 DEPTH=1024, length 01 04 00 00 (1025) -> no wr_en, error=1, state IDLE, in_ready=0.
REQ-037 N=1, in_valid toggled every other cycle -> same single write 0x...@0x0, correct byte order, no extra strobes.
REQ-038 N=2, abort coincident with 7th byte -> only word 0 written, error=1, done never asserted; subsequent start clears error.
REQ-039 rst_n low for one cycle during DATA -> all outputs zero immediately, no wr_en, next start loads normally.
